// File: rtl/query_ctrl_pkg.sv
// rtl/query_ctrl_pkg.sv - shared state encoding and default sizes for query_ctrl
package query_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_W     = 32;
  localparam int DEF_DIM   = 4;
  localparam int DEF_K_MAX = 8;

endpackage

// File: rtl/result_buf.sv
// rtl/result_buf.sv - result storage, one write port, one registered read port
// rd_en gates the read so addresses past the stored count return 0.
module result_buf
  import query_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_K_MAX,
  parameter int W     = DEF_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= rd_en ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/query_ctrl.sv
// rtl/query_ctrl.sv - query vector holder and result collector around a search engine
// Four-state FSM (IDLE/START/RUN/DONE) with k clamp, early done and run timeout.
module query_ctrl
  import query_ctrl_pkg::*;
#(
  parameter int DIM     = DEF_DIM,
  parameter int K_MAX   = DEF_K_MAX,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       q_wr_valid_in,
  input  logic [$clog2(DIM)-1:0]     q_wr_addr_in,
  input  logic [W-1:0]               q_wr_data_in,
  input  logic [15:0]                k_in,
  input  logic                       start_in,
  output logic [DIM*W-1:0]           query_out,
  output logic                       eng_start_out,
  output logic [15:0]                eng_k_out,
  input  logic                       res_valid_in,
  input  logic [W-1:0]               res_id_in,
  input  logic                       res_done_in,
  input  logic [$clog2(K_MAX)-1:0]   rd_addr_in,
  output logic [W-1:0]               rd_data_out,
  output logic [$clog2(K_MAX+1)-1:0] count_out,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       err_out
);

  localparam int RW = $clog2(K_MAX);
  localparam int CW = $clog2(K_MAX + 1);

  state_t        state, state_nx;
  logic [15:0]   k_eff;
  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [31:0]   timer;
  logic          err;
  logic          idle_like, start_ok, store, reach, timeout;
  logic [15:0]   k_clamp;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign start_ok  = start_in && idle_like;
  assign k_clamp   = (k_in > 16'(K_MAX)) ? 16'(K_MAX) : k_in;
  assign store     = (state == ST_RUN) && res_valid_in && (16'(count) < k_eff);
  assign count_inc = count + CW'(store);
  assign reach     = (16'(count_inc) == k_eff);
  assign timeout   = (timer == 32'(TIMEOUT - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_in) state_nx = (k_in == 16'd0) ? ST_DONE : ST_START;
      ST_START:         state_nx = ST_RUN;
      ST_RUN:           if (reach || res_done_in || timeout) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_out      = 1'b0;
    done_out      = 1'b0;
    eng_start_out = 1'b0;
    case (state)
      ST_START: begin busy_out = 1'b1; eng_start_out = 1'b1; end
      ST_RUN:   busy_out = 1'b1;
      ST_DONE:  done_out = 1'b1;
      default:  ;
    endcase
  end

  // An out-of-range write address matches no element and is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      query_out <= '0;
      k_eff     <= '0;
      count     <= '0;
      timer     <= '0;
      err       <= 1'b0;
    end else begin
      if (q_wr_valid_in && idle_like) begin
        for (int i = 0; i < DIM; i++)
          if (32'(q_wr_addr_in) == i) query_out[i*W +: W] <= q_wr_data_in;
      end
      if (start_ok) begin
        k_eff <= k_clamp;
        count <= '0;
        timer <= '0;
        err   <= (k_in == 16'd0);
      end else if (state == ST_RUN) begin
        count <= count_inc;
        timer <= timer + 32'd1;
        if (timeout && !reach && !res_done_in) err <= 1'b1;
      end
    end
  end

  result_buf #(.DEPTH(K_MAX), .W(W), .AW(RW)) u_buf (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (store),
    .wr_addr (count[RW-1:0]),
    .wr_data (res_id_in),
    .rd_en   (32'(rd_addr_in) < 32'(count)),
    .rd_addr (rd_addr_in),
    .rd_data (rd_data_out)
  );

  assign eng_k_out = k_eff;
  assign count_out = count;
  assign err_out   = err;

endmodule

// File: tb/tb_query_ctrl.sv
// tb/tb_query_ctrl.sv - directed self-checking bench for query_ctrl
module tb_query_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         q_wr_valid = 1'b0;
  logic [1:0]   q_wr_addr = '0;
  logic [31:0]  q_wr_data = '0;
  logic [15:0]  k = '0;
  logic         start = 1'b0;
  logic [127:0] query;
  logic         eng_start;
  logic [15:0]  eng_k;
  logic         res_valid = 1'b0;
  logic [31:0]  res_id = '0;
  logic         res_done = 1'b0;
  logic [2:0]   rd_addr = '0;
  logic [31:0]  rd_data;
  logic [3:0]   count;
  logic         busy, done, err;

  int checks = 0;
  int errors = 0;
  logic [127:0] q_exp;

  always #5 clk = ~clk;

  query_ctrl #(.DIM(4), .K_MAX(8), .W(32), .TIMEOUT(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .q_wr_valid_in(q_wr_valid), .q_wr_addr_in(q_wr_addr), .q_wr_data_in(q_wr_data),
    .k_in(k), .start_in(start),
    .query_out(query), .eng_start_out(eng_start), .eng_k_out(eng_k),
    .res_valid_in(res_valid), .res_id_in(res_id), .res_done_in(res_done),
    .rd_addr_in(rd_addr), .rd_data_out(rd_data), .count_out(count),
    .busy_out(busy), .done_out(done), .err_out(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_q(input logic [1:0] a, input logic [31:0] d);
    q_wr_valid = 1'b1; q_wr_addr = a; q_wr_data = d;
    tick();
    q_wr_valid = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] kv);
    start = 1'b1; k = kv;
    tick();
    start = 1'b0;
  endtask

  task automatic send_res(input logic [31:0] id, input logic dn);
    res_valid = 1'b1; res_id = id; res_done = dn;
    tick();
    res_valid = 1'b0; res_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || eng_start !== 1'b0) begin errors++; $display("FAIL reset_flags: got b%0b d%0b e%0b s%0b expected all 0", busy, done, err, eng_start); end
    checks++; if (count !== 4'd0 || query !== 128'd0 || eng_k !== 16'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL reset_data: got cnt=%0d q=%0h k=%0d rd=%0h expected 0", count, query, eng_k, rd_data); end
    rst = 1'b0;
    tick();
    send_res(32'd77, 1'b0);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL idle_result_drop: got %0d expected 0", count); end
  endtask

  task automatic test_basic();
    write_q(2'd0, 32'd5); write_q(2'd1, 32'd7); write_q(2'd2, 32'd1); write_q(2'd3, 32'd1);
    q_exp = {32'd1, 32'd1, 32'd7, 32'd5};
    checks++; if (query !== q_exp) begin errors++; $display("FAIL basic_query: got %0h expected %0h", query, q_exp); end
    do_start(16'd4);
    checks++; if (eng_start !== 1'b1 || busy !== 1'b1 || eng_k !== 16'd4) begin errors++; $display("FAIL basic_start: got s%0b b%0b k%0d expected s1 b1 k4", eng_start, busy, eng_k); end
    tick();
    checks++; if (eng_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_run: got s%0b b%0b expected s0 b1", eng_start, busy); end
    for (int i = 0; i < 3; i++) send_res(32'(10 + i), 1'b0);
    checks++; if (busy !== 1'b1 || count !== 4'd3) begin errors++; $display("FAIL basic_mid: got b%0b cnt=%0d expected b1 cnt=3", busy, count); end
    send_res(32'd13, 1'b0);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd4 || err !== 1'b0) begin errors++; $display("FAIL basic_done: got d%0b b%0b cnt=%0d e%0b expected d1 b0 cnt=4 e0", done, busy, count, err); end
    for (int i = 0; i < 5; i++) begin
      rd_addr = 3'(i);
      tick();
      checks++; if (rd_data !== ((i < 4) ? 32'(10 + i) : 32'd0)) begin errors++; $display("FAIL basic_read%0d: got %0d expected %0d", i, rd_data, (i < 4) ? 10 + i : 0); end
    end
  endtask

  task automatic test_clamp();
    do_start(16'd20);
    checks++; if (eng_start !== 1'b1 || eng_k !== 16'd8) begin errors++; $display("FAIL clamp_start: got s%0b k=%0d expected s1 k=8", eng_start, eng_k); end
    tick();
    for (int i = 0; i < 9; i++) send_res(32'(100 + i), 1'b0);
    checks++; if (count !== 4'd8 || done !== 1'b1 || eng_k !== 16'd8) begin errors++; $display("FAIL clamp_done: got cnt=%0d d%0b k=%0d expected cnt=8 d1 k=8", count, done, eng_k); end
    rd_addr = 3'd7;
    tick();
    checks++; if (rd_data !== 32'd107) begin errors++; $display("FAIL clamp_read7: got %0d expected 107", rd_data); end
  endtask

  task automatic test_early_done();
    do_start(16'd4);
    tick();
    send_res(32'd50, 1'b0);
    send_res(32'd51, 1'b1);
    checks++; if (count !== 4'd2 || done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL early_done: got cnt=%0d d%0b e%0b expected cnt=2 d1 e0", count, done, err); end
    rd_addr = 3'd1; tick();
    checks++; if (rd_data !== 32'd51) begin errors++; $display("FAIL early_read1: got %0d expected 51", rd_data); end
    rd_addr = 3'd2; tick();
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL early_read2: got %0d expected 0", rd_data); end
    rd_addr = 3'd3; tick();
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL early_read3: got %0d expected 0", rd_data); end
  endtask

  task automatic test_timeout();
    do_start(16'd4);
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++; if (busy !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL timeout_before: got b%0b e%0b expected b1 e0", busy, err); end
    tick();
    checks++; if (done !== 1'b1 || err !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL timeout_done: got d%0b e%0b cnt=%0d expected d1 e1 cnt=0", done, err, count); end
    tick(); tick();
    checks++; if (err !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got e%0b d%0b expected e1 d1", err, done); end
  endtask

  task automatic test_kzero_qwrite();
    do_start(16'd4);
    checks++; if (err !== 1'b0 || eng_start !== 1'b1) begin errors++; $display("FAIL kz_err_clear: got e%0b s%0b expected e0 s1", err, eng_start); end
    write_q(2'd0, 32'd99);
    write_q(2'd1, 32'd98);
    q_exp = {32'd1, 32'd1, 32'd7, 32'd5};
    checks++; if (query !== q_exp) begin errors++; $display("FAIL kz_query_locked: got %0h expected %0h", query, q_exp); end
    res_done = 1'b1; tick(); res_done = 1'b0;
    do_start(16'd0);
    checks++; if (done !== 1'b1 || err !== 1'b1 || count !== 4'd0 || eng_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kz_immediate: got d%0b e%0b cnt=%0d s%0b b%0b expected d1 e1 cnt=0 s0 b0", done, err, count, eng_start, busy); end
  endtask

  task automatic test_reset_mid_run();
    do_start(16'd4);
    tick();
    send_res(32'd60, 1'b0);
    send_res(32'd61, 1'b0);
    checks++; if (count !== 4'd2 || busy !== 1'b1) begin errors++; $display("FAIL mid_before: got cnt=%0d b%0b expected cnt=2 b1", count, busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || count !== 4'd0 || query !== 128'd0 || eng_k !== 16'd0) begin errors++; $display("FAIL mid_reset: got b%0b d%0b e%0b cnt=%0d q=%0h k=%0d expected all 0", busy, done, err, count, query, eng_k); end
    rd_addr = 3'd0; tick();
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL mid_read0: got %0d expected 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_early_done();
    test_timeout();
    test_kzero_qwrite();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/query_ctrl.md
QUERY_CTRL -- requirements
Module: query_ctrl

Interface
REQ-001 Parameter DIM, default 4, number of query vector elements.
REQ-002 Parameter K_MAX, default 8, result buffer depth.
REQ-003 Parameter W, default 32, element and result width.
REQ-004 Parameter TIMEOUT, default 65535, maximum RUN cycles before abort.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk_in  in  1  system clock; all state on rising edge.
REQ-007 rst_in  in  1  synchronous active-high reset.
REQ-008 q_wr_valid_in  in  1  query element write strobe.
REQ-009 q_wr_addr_in  in  $clog2(DIM)  query element index.
REQ-010 q_wr_data_in  in  W  query element value.
REQ-011 k_in  in  16  requested result count, sampled on accepted start.
REQ-012 start_in  in  1  search start pulse.
REQ-013 query_out  out  DIM x W  registered query vector to the search engine.
REQ-014 eng_start_out  out  1  one-cycle engine start pulse.
REQ-015 eng_k_out  out  16  latched effective k.
REQ-016 res_valid_in  in  1  engine result strobe.
REQ-017 res_id_in  in  W  result vertex id.
REQ-018 res_done_in  in  1  engine finished, possibly early.
REQ-019 rd_addr_in  in  $clog2(K_MAX)  result readout index.
REQ-020 rd_data_out  out  W  registered readout data.
REQ-021 count_out  out  $clog2(K_MAX+1)  results stored.
REQ-022 busy_out / done_out / err_out  out  1 each  status flags.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, START, RUN and DONE. busy_out=1 in START and RUN. done_out=1 in DONE.
REQ-024 Query writes SHALL be accepted only in IDLE or DONE. Writes in START or RUN, and writes with q_wr_addr_in>=DIM, SHALL be ignored.
REQ-025 A write SHALL update query_out[addr] on the next cycle. query_out SHALL remain stable throughout START and RUN.
REQ-026 start_in SHALL be accepted only in IDLE or DONE; it SHALL be ignored in START and RUN.
REQ-027 On an accepted start, the block SHALL latch k_eff=min(k_in,K_MAX) and clear count, err and the cycle timer.
REQ-028 If k_in=0 on an accepted start, the block SHALL set err_out and go directly to DONE with count_out=0, with no engine start.
REQ-029 START SHALL last one cycle with eng_start_out=1, then enter RUN.
REQ-030 In RUN, each res_valid_in SHALL write res_id_in to buffer[count] and increment count.
REQ-031 RUN SHALL exit to DONE in the same cycle that count reaches k_eff.
REQ-032 res_done_in in RUN SHALL force DONE. If res_valid_in is also asserted, that result SHALL be stored first when count<k_eff.
REQ-033 In RUN, the timer SHALL increment each cycle. At TIMEOUT, the block SHALL enter DONE with err_out=1.
REQ-034 Results arriving outside RUN SHALL be dropped.
REQ-035 err_out SHALL be sticky until the next accepted start or reset.
REQ-036 rd_data_out SHALL have 1-cycle latency. It SHALL read 0 when rd_addr_in>=count_out.
REQ-037 DONE SHALL hold until an accepted start, which SHALL enter START directly.

Reset
REQ-038 rst_in SHALL force IDLE and zero every output, query_out, count, timer, k_eff and err, irrespective of current state.
REQ-039 Reset asserted mid-RUN SHALL discard partial results. Buffer contents after reset SHALL read 0.

Structure
REQ-040 A shared package query_ctrl_pkg SHALL hold the state enum and the default W, DIM and K_MAX constants.
REQ-041 The result storage SHALL be a sub-module result_buf: K_MAX x W, one write port, one registered read port.

Verification
REQ-042 Write query {5,7,1,1}, then start with k_in=4 and 4 results 10,11,12,13 → DONE after the 4th result, count_out=4, reads return 10..13, err_out=0.
REQ-043 Start with k_in=20 (K_MAX=8) and feed 9 results → eng_k_out=8, count_out=8, 9th result dropped.
REQ-044 Start with k=4, then res_valid_in and res_done_in together on the 2nd result → count_out=2, DONE, reads at addresses 2 and 3 return 0.
REQ-045 Start with no results and TIMEOUT=16 → DONE 16 cycles into RUN, err_out=1.
REQ-046 Query write during RUN, plus k_in=0 start → query_out unchanged; immediate DONE, err_out=1, no eng_start_out.
REQ-047 rst_in asserted mid-RUN after 2 results → IDLE, count_out=0, query_out=0, all flags 0 next cycle.
